// File: rtl/clk_div_prog_if.sv
// Control and status bundle for clk_div_prog.
// The master drives enable, ratio load and sync; the slave returns the divided clock and status.
interface clk_div_prog_if #(
  parameter int unsigned CNT_W = 8
);
  logic             en;
  logic [CNT_W-1:0] div_in;
  logic             div_load;
  logic             sync;
  logic             clk_out;
  logic             tick;
  logic [CNT_W-1:0] div_cur;
  logic             pend;

  modport master (
    output en, div_in, div_load, sync,
    input  clk_out, tick, div_cur, pend
  );

  modport slave (
    input  en, div_in, div_load, sync,
    output clk_out, tick, div_cur, pend
  );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with a registered near-50% clock and a tick strobe.
// A new ratio is held pending and only takes effect at a period boundary or on sync.
module clk_div_prog #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DEF_DIV = 4
) (
  input logic           clk_in,
  input logic           rst_n,
  clk_div_prog_if.slave bus
);

  localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] One    = CNT_W'(1);
  localparam logic [CNT_W-1:0] Two    = CNT_W'(2);

  // Ratios 0 and 1 run as divide-by-2.
  function automatic logic [CNT_W-1:0] eff_n(input logic [CNT_W-1:0] d);
    return (d < Two) ? Two : d;
  endfunction

  // ceil(n/2) without widening past CNT_W bits.
  function automatic logic [CNT_W-1:0] half_up(input logic [CNT_W-1:0] n);
    return (n >> 1) + {{(CNT_W-1){1'b0}}, n[0]};
  endfunction

  logic [CNT_W-1:0] r_cnt, r_div_cur, r_pending;
  logic             r_pend, r_clk_out, r_tick;

  logic [CNT_W-1:0] w_n, w_h, w_cnt_inc;
  logic [CNT_W-1:0] w_cnt_d, w_div_cur_d, w_pending_d;
  logic             w_pend_d, w_clk_out_d, w_tick_d, w_bound;

  always_comb begin
    w_n         = eff_n(r_div_cur);
    w_h         = half_up(w_n);
    w_cnt_inc   = r_cnt + One;
    w_bound     = bus.en && (r_cnt == (w_n - One));
    w_cnt_d     = r_cnt;
    w_div_cur_d = r_div_cur;
    w_pending_d = r_pending;
    w_pend_d    = r_pend;
    w_clk_out_d = r_clk_out;
    w_tick_d    = 1'b0;

    if (bus.sync || w_bound) begin
      w_cnt_d     = '0;
      w_clk_out_d = 1'b1;
      w_tick_d    = 1'b1;
      if (r_pend) begin
        w_div_cur_d = r_pending;
        w_pend_d    = 1'b0;
      end
    end else if (bus.en) begin
      w_cnt_d     = w_cnt_inc;
      w_clk_out_d = (w_cnt_inc < w_h);
    end

    // A load on the applying edge re-arms pend with the fresh value for the next boundary.
    if (bus.div_load) begin
      w_pending_d = bus.div_in;
      w_pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= DefDiv - One;
      r_div_cur <= DefDiv;
      r_pending <= DefDiv;
      r_pend    <= 1'b0;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_d;
      r_div_cur <= w_div_cur_d;
      r_pending <= w_pending_d;
      r_pend    <= w_pend_d;
      r_clk_out <= w_clk_out_d;
      r_tick    <= w_tick_d;
    end
  end

  assign bus.clk_out = r_clk_out;
  assign bus.tick    = r_tick;
  assign bus.div_cur = r_div_cur;
  assign bus.pend    = r_pend;

endmodule

// File: tb/tb_clk_div_prog.sv
// Table-driven bench for clk_div_prog: each row is one clock edge of stimulus plus the
// expected registered outputs after that edge.
module tb_clk_div_prog;

  localparam int unsigned CntW = 8;

  logic clk_in = 1'b0;
  logic rst_n;

  always #5 clk_in = ~clk_in;

  clk_div_prog_if #(.CNT_W(CntW)) bus ();

  clk_div_prog #(
    .CNT_W  (CntW),
    .DEF_DIV(4)
  ) dut (
    .clk_in(clk_in),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic            en;
    logic            ld;
    logic [CntW-1:0] din;
    logic            sync;
    logic            clk;
    logic            tick;
    logic [CntW-1:0] dcur;
    logic            pend;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic add(input logic en, input logic ld, input logic [CntW-1:0] din,
                     input logic sync, input logic clk, input logic tick,
                     input logic [CntW-1:0] dcur, input logic pend);
    vec_t v;
    v.en = en; v.ld = ld; v.din = din; v.sync = sync;
    v.clk = clk; v.tick = tick; v.dcur = dcur; v.pend = pend;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [CntW-1:0] act,
                     input logic [CntW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
  endtask

  task automatic apply(input int i);
    bus.en       = vecs[i].en;
    bus.div_load = vecs[i].ld;
    bus.div_in   = vecs[i].din;
    bus.sync     = vecs[i].sync;
    @(posedge clk_in);
    #1;
    chk("clk_out", i, CntW'(bus.clk_out), CntW'(vecs[i].clk));
    chk("tick",    i, CntW'(bus.tick),    CntW'(vecs[i].tick));
    chk("div_cur", i, bus.div_cur,        vecs[i].dcur);
    chk("pend",    i, CntW'(bus.pend),    CntW'(vecs[i].pend));
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.div_load = 1'b0;
    bus.div_in   = '0;
    bus.sync     = 1'b0;

    // N=4 from reset: first enabled edge is a boundary
    add(1,0,0,0, 1,1,4,0); add(1,0,0,0, 1,0,4,0); add(1,0,0,0, 0,0,4,0);
    add(1,0,0,0, 0,0,4,0); add(1,0,0,0, 1,1,4,0); add(1,0,0,0, 1,0,4,0);
    // load 5 at cnt=1, current period finishes at N=4
    add(1,1,5,0, 0,0,4,1); add(1,0,0,0, 0,0,4,1); add(1,0,0,0, 1,1,5,0);
    add(1,0,0,0, 1,0,5,0); add(1,0,0,0, 1,0,5,0); add(1,0,0,0, 0,0,5,0);
    add(1,0,0,0, 0,0,5,0); add(1,0,0,0, 1,1,5,0); add(1,0,0,0, 1,0,5,0);
    add(1,0,0,0, 1,0,5,0); add(1,0,0,0, 0,0,5,0); add(1,0,0,0, 0,0,5,0);
    // load 0 on a boundary edge, then load 1: both run as N=2
    add(1,1,0,0, 1,1,5,1); add(1,0,0,0, 1,0,5,1); add(1,0,0,0, 1,0,5,1);
    add(1,0,0,0, 0,0,5,1); add(1,0,0,0, 0,0,5,1); add(1,0,0,0, 1,1,0,0);
    add(1,0,0,0, 0,0,0,0); add(1,0,0,0, 1,1,0,0); add(1,1,1,0, 0,0,0,1);
    add(1,0,0,0, 1,1,1,0); add(1,0,0,0, 0,0,1,0); add(1,0,0,0, 1,1,1,0);
    // back to N=4, freeze 3 cycles at cnt=1: period becomes 7
    add(1,1,4,0, 0,0,1,1); add(1,0,0,0, 1,1,4,0); add(1,0,0,0, 1,0,4,0);
    add(0,0,0,0, 1,0,4,0); add(0,0,0,0, 1,0,4,0); add(0,0,0,0, 1,0,4,0);
    add(1,0,0,0, 0,0,4,0); add(1,0,0,0, 0,0,4,0); add(1,0,0,0, 1,1,4,0);
    add(1,0,0,0, 1,0,4,0);
    // load 6, sync at cnt=2 applies it at once
    add(1,1,6,0, 0,0,4,1); add(1,0,0,1, 1,1,6,0); add(1,0,0,0, 1,0,6,0);
    add(1,0,0,0, 1,0,6,0); add(1,0,0,0, 0,0,6,0); add(1,0,0,0, 0,0,6,0);
    add(1,0,0,0, 0,0,6,0); add(1,0,0,0, 1,1,6,0);
    // load 7 then 9 in one period: only 9 applies (N=9, H=5)
    add(1,1,7,0, 1,0,6,1); add(1,1,9,0, 1,0,6,1); add(1,0,0,0, 0,0,6,1);
    add(1,0,0,0, 0,0,6,1); add(1,0,0,0, 0,0,6,1); add(1,0,0,0, 1,1,9,0);
    add(1,0,0,0, 1,0,9,0); add(1,0,0,0, 1,0,9,0); add(1,0,0,0, 1,0,9,0);
    add(1,0,0,0, 1,0,9,0); add(1,0,0,0, 0,0,9,0); add(1,0,0,0, 0,0,9,0);
    add(1,0,0,0, 0,0,9,0); add(1,0,0,0, 0,0,9,0); add(1,0,0,0, 1,1,9,0);
    // sync with simultaneous load: old pending 3 applies now, 2 waits for next boundary
    add(1,1,3,0, 1,0,9,1); add(1,1,2,1, 1,1,3,1); add(1,0,0,0, 1,0,3,1);
    add(1,0,0,0, 0,0,3,1); add(1,0,0,0, 1,1,2,0); add(1,0,0,0, 0,0,2,0);
    add(1,0,0,0, 1,1,2,0);
    // sync overrides en=0
    add(0,0,0,1, 1,1,2,0);

    #12;
    chk("rst_clk_out", -1, CntW'(bus.clk_out), '0);
    chk("rst_tick",    -1, CntW'(bus.tick),    '0);
    chk("rst_div_cur", -1, bus.div_cur,        CntW'(4));
    chk("rst_pend",    -1, CntW'(bus.pend),    '0);
    @(negedge clk_in);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(i);

    // Async reset mid-period with a pending load and clk_out high
    bus.en       = 1'b0;
    bus.div_load = 1'b1;
    bus.div_in   = CntW'(5);
    bus.sync     = 1'b0;
    @(posedge clk_in);
    #1;
    bus.div_load = 1'b0;
    chk("pre_rst_pend",    -2, CntW'(bus.pend),    CntW'(1));
    chk("pre_rst_clk_out", -2, CntW'(bus.clk_out), CntW'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_clk_out", -3, CntW'(bus.clk_out), '0);
    chk("async_tick",    -3, CntW'(bus.tick),    '0);
    chk("async_div_cur", -3, bus.div_cur,        CntW'(4));
    chk("async_pend",    -3, CntW'(bus.pend),    '0);
    @(negedge clk_in);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) apply(i);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
